// File: rtl/dmem_pkg.sv
// Shared types, policy constants and the byte-lane merge helper for the data memory bank.
package dmem_pkg;

    // Bank sequencing: clear the array after reset, then serve traffic.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Read-during-write collision policies.
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word the merge helper handles; DATA_W must not exceed this.
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / 8;

    // Replace the byte lanes of old_word selected by be with the lanes of new_word.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BE; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// Write/read bus of the data memory bank; the datapath side is master, the bank is slave.
interface dmem_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int NRD    = 2
);
    logic                  ready;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_adr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     dat_in;
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_adr;
    logic [NRD*DATA_W-1:0] dat_out;
    logic [NRD-1:0]        rd_valid;

    modport master (
        input  ready, dat_out, rd_valid,
        output wr_en, wr_adr, wr_be, dat_in, rd_en, rd_adr
    );

    modport slave (
        output ready, dat_out, rd_valid,
        input  wr_en, wr_adr, wr_be, dat_in, rd_en, rd_adr
    );
endinterface

// File: rtl/dmem_rd_port.sv
// One registered read port: collision mux, output data register and valid flag.
module dmem_rd_port
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int RD_MODE = RD_FIRST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_adr,
    input  logic [DATA_W-1:0]   raw_word,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_adr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   dat_in,
    output logic [DATA_W-1:0]   dat_out,
    output logic                rd_valid
);

    logic              collide;
    logic [DATA_W-1:0] read_word;

    // Pick the word to capture: the stored word, or in write-first mode the word as it will look after this edge's write.
    always_comb begin
        collide   = wr_en && (wr_adr == rd_adr) && (RD_MODE == WR_FIRST);
        read_word = raw_word;
        if (collide) begin
            read_word = DATA_W'(byte_merge(MAX_W'(raw_word), MAX_W'(dat_in), MAX_BE'(wr_be)));
        end
    end

    // Capture read data on an accepted read; otherwise hold the data and drop valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_out  <= '0;
            rd_valid <= 1'b0;
        end else if (run && rd_en) begin
            dat_out  <= read_word;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_bank.sv
// Byte-enabled single-write, multi-read data memory with a post-reset clear walker.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 10,
    parameter int              NRD       = 2,
    parameter int              RD_MODE   = RD_FIRST,
    parameter int              INIT_EN   = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input logic        clk,
    input logic        reset,
    dmem_bank_if.slave bus
);

    localparam int     DEPTH       = 2 ** ADDR_W;
    localparam state_t RESET_STATE = (INIT_EN != 0) ? INIT : RUN;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   init_ptr;
    logic [ADDR_W-1:0]   next_ptr;
    logic                run;
    logic                run_wr;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_adr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   port_data  [NRD];
    logic                port_valid [NRD];

    // State and clear pointer; reset restarts the full clear sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            init_ptr <= '0;
        end else begin
            state    <= next_state;
            init_ptr <= next_ptr;
        end
    end

    // INIT walks the array writing CLEAR_VAL; RUN forwards the byte-merged bus write.
    always_comb begin
        next_state = state;
        next_ptr   = init_ptr;
        run        = 1'b0;
        mem_we     = 1'b0;
        mem_adr    = bus.wr_adr;
        mem_wdata  = DATA_W'(byte_merge(MAX_W'(mem[bus.wr_adr]), MAX_W'(bus.dat_in), MAX_BE'(bus.wr_be)));
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_adr   = init_ptr;
                mem_wdata = CLEAR_VAL;
                next_ptr  = init_ptr + 1'b1;
                if (init_ptr == {ADDR_W{1'b1}}) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                run    = 1'b1;
                mem_we = bus.wr_en;
            end
            default: begin
                next_state = RESET_STATE;
            end
        endcase
    end

    assign run_wr    = run & bus.wr_en;
    assign bus.ready = run;

    // Array write port; the array itself is never reset, and edges while reset is held write nothing.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_adr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] adr;
        assign adr = bus.rd_adr[p*ADDR_W +: ADDR_W];

        dmem_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .RD_MODE (RD_MODE)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .run      (run),
            .rd_en    (bus.rd_en[p]),
            .rd_adr   (adr),
            .raw_word (mem[adr]),
            .wr_en    (run_wr),
            .wr_adr   (bus.wr_adr),
            .wr_be    (bus.wr_be),
            .dat_in   (bus.dat_in),
            .dat_out  (port_data[p]),
            .rd_valid (port_valid[p])
        );
    end

    // Pack the per-port results onto the bus.
    always_comb begin
        bus.dat_out  = '0;
        bus.rd_valid = '0;
        for (int p = 0; p < NRD; p++) begin
            bus.dat_out[p*DATA_W +: DATA_W] = port_data[p];
            bus.rd_valid[p]                 = port_valid[p];
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: a read-first and a write-first bank driven in lockstep.
module tb_dmem_bank;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [9:0]  wr_adr;
    logic [1:0]  wr_be;
    logic [15:0] dat_in;
    logic [1:0]  rd_en;
    logic [19:0] rd_adr;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        wr_en;
        logic [9:0]  wr_adr;
        logic [1:0]  wr_be;
        logic [15:0] dat_in;
        logic [1:0]  rd_en;
        logic [9:0]  adr0;
        logic [9:0]  adr1;
        logic [1:0]  exp_valid;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
        logic [15:0] exp_b0;
        logic [15:0] exp_b1;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    dmem_bank_if #(.DATA_W(16), .ADDR_W(10), .NRD(2)) bus_a ();
    dmem_bank_if #(.DATA_W(16), .ADDR_W(10), .NRD(2)) bus_b ();

    assign bus_a.wr_en  = wr_en;
    assign bus_a.wr_adr = wr_adr;
    assign bus_a.wr_be  = wr_be;
    assign bus_a.dat_in = dat_in;
    assign bus_a.rd_en  = rd_en;
    assign bus_a.rd_adr = rd_adr;
    assign bus_b.wr_en  = wr_en;
    assign bus_b.wr_adr = wr_adr;
    assign bus_b.wr_be  = wr_be;
    assign bus_b.dat_in = dat_in;
    assign bus_b.rd_en  = rd_en;
    assign bus_b.rd_adr = rd_adr;

    dmem_bank #(
        .DATA_W(16), .ADDR_W(10), .NRD(2), .RD_MODE(0), .INIT_EN(1), .CLEAR_VAL(16'h0000)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    dmem_bank #(
        .DATA_W(16), .ADDR_W(10), .NRD(2), .RD_MODE(1), .INIT_EN(1), .CLEAR_VAL(16'h0000)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_en  = v.wr_en;
        wr_adr = v.wr_adr;
        wr_be  = v.wr_be;
        dat_in = v.dat_in;
        rd_en  = v.rd_en;
        rd_adr = {v.adr1, v.adr0};
    endtask

    task automatic idleInputs();
        wr_en  = 1'b0;
        wr_adr = '0;
        wr_be  = '0;
        dat_in = '0;
        rd_en  = '0;
        rd_adr = '0;
    endtask

    // Count edges until both banks are ready, noting any read activity while clearing.
    task automatic waitReady(output int edges, output logic leak);
        edges = 0;
        leak  = 1'b0;
        while (!(bus_a.ready && bus_b.ready) && edges < 2000) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus_a.rd_valid != 0 || bus_b.rd_valid != 0 ||
                bus_a.dat_out != 0 || bus_b.dat_out != 0) begin
                leak = 1'b1;
            end
        end
    endtask

    initial begin
        int   edges;
        logic leak;

        tests_run    = 0;
        tests_failed = 0;

        //          wr   adr     be     data      rd     adr0    adr1   valid  a0        a1        b0        b1
        vecs[0]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b01, 10'h003, 10'h000, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b11, 10'h3FF, 10'h000, 2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 10'h005, 2'b11, 16'hBEEF, 2'b00, 10'h000, 10'h000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b01, 10'h005, 10'h000, 2'b01, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[4]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b00, 10'h005, 10'h000, 2'b00, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b1, 10'h005, 2'b01, 16'h1234, 2'b00, 10'h000, 10'h000, 2'b00, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[6]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b01, 10'h005, 10'h000, 2'b01, 16'hBE34, 16'h0000, 16'hBE34, 16'h0000};
        vecs[7]  = '{1'b1, 10'h005, 2'b00, 16'hFFFF, 2'b10, 10'h000, 10'h005, 2'b10, 16'hBE34, 16'hBE34, 16'hBE34, 16'hBE34};
        vecs[8]  = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b01, 10'h005, 10'h000, 2'b01, 16'hBE34, 16'hBE34, 16'hBE34, 16'hBE34};
        vecs[9]  = '{1'b1, 10'h007, 2'b11, 16'hAAAA, 2'b00, 10'h000, 10'h000, 2'b00, 16'hBE34, 16'hBE34, 16'hBE34, 16'hBE34};
        vecs[10] = '{1'b1, 10'h007, 2'b11, 16'h5555, 2'b10, 10'h000, 10'h007, 2'b10, 16'hBE34, 16'hAAAA, 16'hBE34, 16'h5555};
        vecs[11] = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b11, 10'h007, 10'h007, 2'b11, 16'h5555, 16'h5555, 16'h5555, 16'h5555};
        vecs[12] = '{1'b1, 10'h007, 2'b01, 16'h00CC, 2'b01, 10'h007, 10'h000, 2'b01, 16'h5555, 16'h5555, 16'h55CC, 16'h5555};
        vecs[13] = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b11, 10'h007, 10'h007, 2'b11, 16'h55CC, 16'h55CC, 16'h55CC, 16'h55CC};
        vecs[14] = '{1'b1, 10'h009, 2'b10, 16'h1111, 2'b11, 10'h009, 10'h007, 2'b11, 16'h0000, 16'h55CC, 16'h1100, 16'h55CC};
        vecs[15] = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b01, 10'h009, 10'h000, 2'b01, 16'h1100, 16'h55CC, 16'h1100, 16'h55CC};
        vecs[16] = '{1'b1, 10'h008, 2'b11, 16'h7777, 2'b10, 10'h000, 10'h009, 2'b10, 16'h1100, 16'h1100, 16'h1100, 16'h1100};
        vecs[17] = '{1'b1, 10'h3FF, 2'b11, 16'hABCD, 2'b11, 10'h3FF, 10'h000, 2'b11, 16'h0000, 16'h0000, 16'hABCD, 16'h0000};
        vecs[18] = '{1'b0, 10'h000, 2'b00, 16'h0000, 2'b11, 10'h3FF, 10'h3FF, 2'b11, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD};

        reset = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_ready_a", 32'(bus_a.ready), 32'd0);
        checkOutput("rst_ready_b", 32'(bus_b.ready), 32'd0);
        checkOutput("rst_valid_a", 32'(bus_a.rd_valid), 32'd0);
        checkOutput("rst_valid_b", 32'(bus_b.rd_valid), 32'd0);
        checkOutput("rst_dout_a", bus_a.dat_out, 32'd0);
        checkOutput("rst_dout_b", bus_b.dat_out, 32'd0);

        // Traffic during the clear must be ignored, including a write that lands after the walker passed it.
        wr_en  = 1'b1;
        wr_adr = 10'h003;
        wr_be  = 2'b11;
        dat_in = 16'hFFFF;
        rd_en  = 2'b11;
        rd_adr = {10'h003, 10'h003};
        reset  = 1'b0;

        waitReady(edges, leak);
        checkOutput("init_edges", 32'(edges), 32'd1024);
        checkOutput("init_quiet", 32'(leak), 32'd0);
        idleInputs();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_valid_a", i), 32'(bus_a.rd_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d_valid_b", i), 32'(bus_b.rd_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d_dout_a", i), bus_a.dat_out, {vecs[i].exp_a1, vecs[i].exp_a0});
            checkOutput($sformatf("v%0d_dout_b", i), bus_b.dat_out, {vecs[i].exp_b1, vecs[i].exp_b0});
        end

        // Reset in RUN clears the read outputs without a clock edge.
        idleInputs();
        rd_en  = 2'b11;
        rd_adr = {10'h005, 10'h005};
        @(posedge clk);
        #1;
        idleInputs();
        checkOutput("run_valid_a", 32'(bus_a.rd_valid), 32'd3);
        checkOutput("run_dout_a", bus_a.dat_out, {16'hBE34, 16'hBE34});
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid_a", 32'(bus_a.rd_valid), 32'd0);
        checkOutput("async_valid_b", 32'(bus_b.rd_valid), 32'd0);
        checkOutput("async_dout_a", bus_a.dat_out, 32'd0);
        checkOutput("async_dout_b", bus_b.dat_out, 32'd0);
        checkOutput("async_ready_a", 32'(bus_a.ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset 100 edges into the clear restarts the full sweep.
        repeat (100) @(posedge clk);
        #1;
        checkOutput("mid_init_ready", 32'(bus_a.ready), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready_a", 32'(bus_a.ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitReady(edges, leak);
        checkOutput("reinit_edges", 32'(edges), 32'd1024);

        // Words written before the reset are cleared again.
        rd_en  = 2'b11;
        rd_adr = {10'h007, 10'h005};
        @(posedge clk);
        #1;
        idleInputs();
        checkOutput("reinit_valid_a", 32'(bus_a.rd_valid), 32'd3);
        checkOutput("reinit_dout_a", bus_a.dat_out, 32'd0);
        checkOutput("reinit_dout_b", bus_b.dat_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
Parametrised synchronous data memory for the hw pipelines. It has one byte-enabled write port and NRD independent registered read ports.
- A post-reset init walker clears every word to CLEAR_VAL before the bank accepts traffic.
- A configurable read-during-write policy resolves same-cycle collisions.
- It sits between the memory stage and the load/store datapath, replacing the fixed 16-bit, 1 KiB single-read memory.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
NRD, 2, number of read ports (1..4)
RD_MODE, 0, collision policy: 0 = read-first (old data), 1 = write-first (merged new data)
INIT_EN, 1, 1 = clear memory after reset; 0 = skip init, bank ready immediately
CLEAR_VAL, 0, value written to every word during init

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ready  out  1  high when the bank accepts reads and writes
wr_en  in  1  write strobe, sampled at rising edge
wr_adr  in  ADDR_W  write address
wr_be  in  DATA_W/8  byte-lane enables; bit b covers dat_in[8b+7:8b]
dat_in  in  DATA_W  write data
rd_en  in  NRD  per-port read strobe
rd_adr  in  NRD*ADDR_W  packed read addresses; port p uses slice p
dat_out  out  NRD*DATA_W  packed registered read data
rd_valid  out  NRD  per-port: dat_out slice holds fresh read data

Behaviour:
- Reset asserted, asynchronously:
  - state=INIT and init_ptr=0 (or state=RUN if INIT_EN=0).
  - ready=0 (1 if INIT_EN=0); rd_valid=0; dat_out=0.
  - Memory array contents are not touched by reset itself.
- FSM states are INIT and RUN.
- INIT:
  - Each rising edge writes CLEAR_VAL to mem[init_ptr], then init_ptr++.
  - The edge that writes DEPTH-1 moves to RUN.
  - ready rises after exactly DEPTH edges following reset deassertion.
- During INIT:
  - wr_en and rd_en are ignored: no write, rd_valid stays 0, dat_out holds 0.
- Reset in any state, including mid-INIT, restarts from the beginning; the full DEPTH-cycle clear repeats.
- RUN writes: when wr_en=1 at a rising edge, each lane b with wr_be[b]=1 takes the matching dat_in byte. Other lanes keep their old value.
  - wr_en=1 with wr_be=0 is a no-op.
- RUN reads: 1-cycle latency.
  - rd_en[p]=1 at edge N: dat_out slice p = mem[rd_adr slice p] after edge N, and rd_valid[p]=1 for that cycle.
  - rd_en[p]=0 at edge N: rd_valid[p]=0 after edge N, and dat_out slice p holds its previous value.
- Ports are fully independent. Any number of read ports may target the same address and receive identical data.
- Collision (wr_en=1 and rd_en[p]=1 with equal addresses at the same edge):
  - RD_MODE=0: port p returns pre-write data.
  - RD_MODE=1: port p returns the word with enabled lanes replaced by dat_in.
  - In both modes the memory is updated. A read at the next edge returns the new word.
- Addresses index 0..DEPTH-1 with no bounds check; every ADDR_W value is valid.
- No back-pressure: one write plus NRD reads are accepted every RUN cycle.

Decomposition:
- Package dmem_pkg:
  - state enum {INIT, RUN}
  - RD_FIRST=0 and WR_FIRST=1 constants
  - a byte-merge function: old word, new word, be -> merged word
- Sub-module dmem_rd_port, instantiated NRD times via generate. It holds the output register, the rd_valid flop and the collision mux. Its inputs are the raw array word plus the write-side signals.
- The INIT/RUN FSM and the array stay in dmem_bank.

Test Plan:
- Defaults: hold reset 2 cycles, then release. ready=0 for exactly 1024 edges, then 1. Reading 0x3FF and 0x000 on ports 0 and 1 returns 0x0000 with rd_valid=1 one cycle later.
- Write adr 0x005, 0xBEEF, be=2'b11. Next cycle read port0 adr 0x005 -> dat_out[15:0]=0xBEEF with rd_valid[0]=1. Then drop rd_en -> rd_valid[0]=0 and data holds 0xBEEF.
- With mem[5]=0xBEEF, write 0x1234 be=2'b01 -> read returns 0xBE34. Write be=2'b00 -> still 0xBE34.
- With mem[7]=0xAAAA, same edge: write 0x5555 be=11 and read port1 adr 7. RD_MODE=0 -> 0xAAAA; RD_MODE=1 -> 0x5555. Read the following cycle -> 0x5555 in both builds.
- During INIT, drive wr_en=1 adr 3 data 0xFFFF and rd_en=2'b11 -> rd_valid stays 0. After ready, read adr 3 -> 0x0000.
- Assert reset at cycle 100 of INIT -> ready=0 immediately, then 1024 further edges before ready=1. Assert reset in RUN with rd_valid=1 -> rd_valid and dat_out go to 0 without waiting for a clock edge.
